// File: rtl/ex_div.sv
// Iterative radix-2 signed/unsigned divider for the EX stage: result_o = {remainder, quotient}.
// Define EX_DIV_ZERO_FLAG_EN to add the div_zero_o divide-by-zero flag output.
module ex_div #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  busy_o
`ifdef EX_DIV_ZERO_FLAG_EN
    ,
    output logic                  div_zero_o
`endif
);

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [2*DATA_W:0]   dividend;
    logic [DATA_W-1:0]   divisor;
    logic                neg_q;
    logic                neg_r;

    logic                op1_neg, op2_neg;
    logic [DATA_W-1:0]   op1_abs, op2_abs;
    logic [DATA_W:0]     diff;
    logic [DATA_W-1:0]   quot, rem, quot_s, rem_s;

    assign op1_neg = signed_div_i & opdata1_i[DATA_W-1];
    assign op2_neg = signed_div_i & opdata2_i[DATA_W-1];
    assign op1_abs = op1_neg ? -opdata1_i : opdata1_i;
    assign op2_abs = op2_neg ? -opdata2_i : opdata2_i;

    // Trial subtraction of the divisor from the top of the partial remainder.
    assign diff   = dividend[2*DATA_W:DATA_W] - {1'b0, divisor};
    assign quot   = dividend[DATA_W-1:0];
    assign rem    = dividend[2*DATA_W:DATA_W+1];
    assign quot_s = neg_q ? -quot : quot;
    assign rem_s  = neg_r ? -rem : rem;

    assign busy_o = (state == ON) || (state == BYZERO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FREE;
            cnt      <= '0;
            dividend <= '0;
            divisor  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
`ifdef EX_DIV_ZERO_FLAG_EN
            div_zero_o <= 1'b0;
`endif
        end else begin
            case (state)
                FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state <= BYZERO;
                        end else begin
                            state    <= ON;
                            cnt      <= '0;
                            dividend <= {{DATA_W{1'b0}}, op1_abs, 1'b0};
                            divisor  <= op2_abs;
                            neg_q    <= op1_neg ^ op2_neg;
                            neg_r    <= op1_neg;
                        end
                    end
                end
                BYZERO: begin
                    if (annul_i) begin
                        state <= FREE;
                    end else begin
                        state    <= END;
                        result_o <= '0;
                        ready_o  <= 1'b1;
`ifdef EX_DIV_ZERO_FLAG_EN
                        div_zero_o <= 1'b1;
`endif
                    end
                end
                ON: begin
                    // Annul wins even on the completion edge.
                    if (annul_i) begin
                        state <= FREE;
                    end else if (cnt != LAST) begin
                        if (diff[DATA_W])
                            dividend <= {dividend[2*DATA_W-1:0], 1'b0};
                        else
                            dividend <= {diff[DATA_W-1:0], dividend[DATA_W-1:0], 1'b1};
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        result_o <= {rem_s, quot_s};
                        ready_o  <= 1'b1;
                        state    <= END;
                    end
                end
                END: begin
                    if (!start_i || annul_i) begin
                        state    <= FREE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
`ifdef EX_DIV_ZERO_FLAG_EN
                        div_zero_o <= 1'b0;
`endif
                    end
                end
                default: state <= FREE;
            endcase
        end
    end

endmodule
